// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_start,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_data_rs1,
    input  logic [XLEN-1:0] in_data_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_flush,
    output logic            out_stall,
    output logic            out_busy,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_nxt;
    logic [4:0] count;
    logic [2:0] op;
    logic [4:0] rd_q;
    logic neg_res, neg_rem, special;
    logic [XLEN-1:0] spec_q;
    logic [2*XLEN-1:0] acc, mcand, acc_nxt, prod;
    logic [XLEN-1:0] mplr, rem, quo, dvsr;

    logic fire, last, sgn_a, sgn_b, neg_a, neg_b;
    logic div_zero, div_ovf, ge;
    logic [XLEN-1:0] mag_a, mag_b, spec_val;
    logic [XLEN-1:0] rem_nxt, quo_nxt, mul_res, div_res;
    logic [XLEN:0] trial;

    assign fire = (state == IDLE) & in_start & ~in_flush;
    assign last = (count == 5'd31);

    assign sgn_a = (in_funct3 == 3'b001) | (in_funct3 == 3'b010)
                 | (in_funct3[2] & ~in_funct3[0]);
    assign sgn_b = (in_funct3 == 3'b001) | (in_funct3[2] & ~in_funct3[0]);
    assign neg_a = sgn_a & in_data_rs1[XLEN-1];
    assign neg_b = sgn_b & in_data_rs2[XLEN-1];
    assign mag_a = neg_a ? -in_data_rs1 : in_data_rs1;
    assign mag_b = neg_b ? -in_data_rs2 : in_data_rs2;

    assign div_zero = in_funct3[2] & (in_data_rs2 == '0);
    assign div_ovf  = in_funct3[2] & ~in_funct3[0]
                    & (in_data_rs1 == MIN_INT) & (in_data_rs2 == '1);

    always_comb begin
        spec_val = '0;
        if (div_zero)
            spec_val = in_funct3[1] ? in_data_rs1 : '1;
        else if (!in_funct3[1])
            spec_val = MIN_INT;
    end

    assign acc_nxt = acc + (mplr[0] ? mcand : '0);
    assign prod    = neg_res ? -acc_nxt : acc_nxt;
    assign mul_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign trial   = {rem, quo[XLEN-1]};
    assign ge      = trial >= {1'b0, dvsr};
    assign rem_nxt = ge ? trial[XLEN-1:0] - dvsr : trial[XLEN-1:0];
    assign quo_nxt = {quo[XLEN-2:0], ge};
    assign div_res = op[1] ? (neg_rem ? -rem_nxt : rem_nxt)
                           : (neg_res ? -quo_nxt : quo_nxt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Special cases pass one cycle through DIV without iterating.
    always_comb begin
        state_nxt = state;
        if (in_flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_start) state_nxt = in_funct3[2] ? DIV : MUL;
                MUL:     if (last) state_nxt = DONE;
                DIV:     if (last || special) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        out_busy  = (state != IDLE);
        out_valid = (state == DONE);
        out_stall = fire | (state == MUL) | (state == DIV);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            op         <= '0;
            rd_q       <= '0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            special    <= 1'b0;
            spec_q     <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplr       <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
            out_result <= '0;
            out_rd     <= '0;
        end else begin
            if ((state == MUL || state == DIV) && !last && !in_flush)
                count <= count + 5'd1;
            else
                count <= '0;
            if (fire) begin
                op      <= in_funct3;
                rd_q    <= in_rd;
                neg_res <= neg_a ^ neg_b;
                neg_rem <= neg_a;
                special <= div_zero | div_ovf;
                spec_q  <= spec_val;
                acc     <= '0;
                mcand   <= {{XLEN{1'b0}}, mag_b};
                mplr    <= mag_a;
                rem     <= '0;
                quo     <= mag_a;
                dvsr    <= mag_b;
            end
            if (state == MUL) begin
                acc   <= acc_nxt;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
            end
            if (state == DIV) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
            end
            if (state_nxt == DONE) begin
                out_rd <= rd_q;
                if (special)
                    out_result <= spec_q;
                else
                    out_result <= (state == MUL) ? mul_res : div_res;
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed testbench for ex_muldiv_unit.
// Each task drives one scenario and checks against hand-computed values.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_start = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_data_rs1 = '0;
    logic [31:0] in_data_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic        in_flush = 1'b0;
    logic        out_stall, out_busy, out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    int n_checks = 0;
    int n_fail = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_start(in_start),
        .in_funct3(in_funct3), .in_data_rs1(in_data_rs1),
        .in_data_rs2(in_data_rs2), .in_rd(in_rd), .in_flush(in_flush),
        .out_stall(out_stall), .out_busy(out_busy), .out_valid(out_valid),
        .out_result(out_result), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    // Drives one op and waits for out_valid; returns at #1 after the DONE edge.
    task automatic issue_op(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd,
                            output logic [31:0] res, output logic [4:0] rdo,
                            output int lat, output bit stall_ok);
        int w;
        w = 0;
        @(negedge clk);
        while (out_busy === 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        in_start = 1'b1;
        in_funct3 = f3;
        in_data_rs1 = a;
        in_data_rs2 = b;
        in_rd = rd;
        #1;
        stall_ok = (out_stall === 1'b1);
        @(posedge clk);
        #1;
        in_start = 1'b0;
        in_data_rs1 = $urandom;
        in_data_rs2 = $urandom;
        in_funct3 = 3'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin
            if (out_stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_result;
        rdo = out_rd;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({out_busy, out_valid, out_stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 000", {out_busy, out_valid, out_stall});
        end
        n_checks++;
        if ({out_result, out_rd} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_data got %h/%h exp 0/0", out_result, out_rd);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] res;
        logic [4:0] rdo;
        int lat;
        bit sok;
        issue_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, res, rdo, lat, sok);
        n_checks++;
        if (res !== 32'hFFFFFFEB) begin
            n_fail++;
            $display("FAIL mul_result got %h exp ffffffeb", res);
        end
        n_checks++;
        if (rdo !== 5'd5) begin
            n_fail++;
            $display("FAIL mul_rd got %0d exp 5", rdo);
        end
        n_checks++;
        if (lat !== 32) begin
            n_fail++;
            $display("FAIL mul_latency got %0d exp 32", lat);
        end
        n_checks++;
        if (!sok || out_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_stall busy_ok=%0d done_stall=%b exp 1/0", sok, out_stall);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_busy !== 1'b0 || out_result !== 32'hFFFFFFEB) begin
            n_fail++;
            $display("FAIL mul_pulse valid=%b busy=%b res=%h exp 0/0/ffffffeb",
                     out_valid, out_busy, out_result);
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  f3 [5] = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b001};
        logic [31:0] a  [5] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFFFD, 32'hFFFFFFFD};
        logic [31:0] b  [5] = '{32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd5, 32'd5};
        logic [31:0] ex [5] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                32'hFFFFFFF1, 32'hFFFFFFFF};
        logic [31:0] res;
        logic [4:0] rdo;
        int lat;
        bit sok;
        for (int i = 0; i < 5; i++) begin
            issue_op(f3[i], a[i], b[i], 5'(i + 1), res, rdo, lat, sok);
            n_checks++;
            if (res !== ex[i] || lat !== 32) begin
                n_fail++;
                $display("FAIL mulh_%0d got %h lat %0d exp %h lat 32", i, res, lat, ex[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3 [6] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100, 3'b111};
        logic [31:0] a  [6] = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFEC,
                                32'hFFFFFFEC, 32'd7, 32'd100};
        logic [31:0] b  [6] = '{32'd7, 32'd2, 32'd3, 32'd3, 32'hFFFFFFFE, 32'd7};
        logic [31:0] ex [6] = '{32'd14, 32'hFFFFFFFF, 32'hFFFFFFFA,
                                32'hFFFFFFFE, 32'hFFFFFFFD, 32'd2};
        logic [31:0] res;
        logic [4:0] rdo;
        int lat;
        bit sok;
        for (int i = 0; i < 6; i++) begin
            issue_op(f3[i], a[i], b[i], 5'(i + 10), res, rdo, lat, sok);
            n_checks++;
            if (res !== ex[i] || lat !== 32 || rdo !== 5'(i + 10)) begin
                n_fail++;
                $display("FAIL div_%0d got %h lat %0d rd %0d exp %h lat 32 rd %0d",
                         i, res, lat, rdo, ex[i], i + 10);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3 [4] = '{3'b100, 3'b100, 3'b110, 3'b111};
        logic [31:0] a  [4] = '{32'h12345678, 32'h80000000, 32'h80000000, 32'd5};
        logic [31:0] b  [4] = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] ex [4] = '{32'hFFFFFFFF, 32'h80000000, 32'd0, 32'd5};
        logic [31:0] res;
        logic [4:0] rdo;
        int lat;
        bit sok;
        for (int i = 0; i < 4; i++) begin
            issue_op(f3[i], a[i], b[i], 5'(i + 20), res, rdo, lat, sok);
            n_checks++;
            if (res !== ex[i] || lat !== 1 || !sok) begin
                n_fail++;
                $display("FAIL special_%0d got %h lat %0d stall_ok %0d exp %h lat 1",
                         i, res, lat, sok, ex[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [4:0] rdo;
        int lat;
        int seen;
        bit sok;
        @(negedge clk);
        while (out_busy === 1'b1) @(negedge clk);
        in_start = 1'b1;
        in_funct3 = 3'b100;
        in_data_rs1 = 32'd1000;
        in_data_rs2 = 32'd3;
        in_rd = 5'd3;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        in_flush = 1'b1;
        #1;
        n_checks++;
        if (out_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre_stall got %b exp 1", out_stall);
        end
        @(posedge clk);
        #1;
        in_flush = 1'b0;
        n_checks++;
        if ({out_busy, out_stall, out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_idle got %b exp 000", {out_busy, out_stall, out_valid});
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0 || out_result !== 32'd5) begin
            n_fail++;
            $display("FAIL flush_no_result valids %0d res %h exp 0 and 00000005", seen, out_result);
        end
        @(negedge clk);
        in_start = 1'b1;
        in_flush = 1'b1;
        in_funct3 = 3'b000;
        #1;
        n_checks++;
        if (out_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_beats_start_stall got %b exp 0", out_stall);
        end
        @(posedge clk);
        #1;
        in_start = 1'b0;
        in_flush = 1'b0;
        n_checks++;
        if (out_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_beats_start_busy got %b exp 0", out_busy);
        end
        issue_op(3'b000, 32'd6, 32'd7, 5'd9, res, rdo, lat, sok);
        n_checks++;
        if (res !== 32'd42 || rdo !== 5'd9 || lat !== 32) begin
            n_fail++;
            $display("FAIL flush_then_mul got %h rd %0d lat %0d exp 0000002a rd 9 lat 32",
                     res, rdo, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        logic [4:0] rdo;
        int lat;
        bit sok;
        @(negedge clk);
        while (out_busy === 1'b1) @(negedge clk);
        in_start = 1'b1;
        in_funct3 = 3'b000;
        in_data_rs1 = 32'd3;
        in_data_rs2 = 32'd4;
        in_rd = 5'd7;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_busy, out_valid, out_stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset_flags got %b exp 000", {out_busy, out_valid, out_stall});
        end
        n_checks++;
        if (out_result !== 32'd0 || out_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL async_reset_data got %h/%0d exp 0/0", out_result, out_rd);
        end
        @(negedge clk);
        reset = 1'b1;
        issue_op(3'b101, 32'd100, 32'd7, 5'd12, res, rdo, lat, sok);
        n_checks++;
        if (res !== 32'd14 || rdo !== 5'd12 || lat !== 32) begin
            n_fail++;
            $display("FAIL async_reset_recover got %h rd %0d lat %0d exp 0000000e rd 12 lat 32",
                     res, rdo, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        logic [4:0] d1, d2;
        int l1, l2;
        bit s1, s2;
        issue_op(3'b011, 32'h00010000, 32'h00010000, 5'd30, r1, d1, l1, s1);
        issue_op(3'b101, 32'd1000, 32'd3, 5'd31, r2, d2, l2, s2);
        n_checks++;
        if (r1 !== 32'd1 || d1 !== 5'd30 || l1 !== 32) begin
            n_fail++;
            $display("FAIL b2b_first got %h rd %0d lat %0d exp 00000001 rd 30 lat 32", r1, d1, l1);
        end
        n_checks++;
        if (r2 !== 32'd333 || d2 !== 5'd31 || l2 !== 32 || !s2) begin
            n_fail++;
            $display("FAIL b2b_second got %h rd %0d lat %0d exp 0000014d rd 31 lat 32", r2, d2, l2);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
